// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: bridges a level-signalled CPU memory request onto a
// synchronous single-port RAM. Every access takes a fixed number of cycles
// (IDLE -> ACCESS -> LATCH -> [WAIT...] -> DONE). Unmapped or misaligned
// addresses are suppressed on the RAM side and recorded in the error registers.
module mem_bus_ctrl #(
  parameter int RAM_AW      = 18,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       cpu_addr,
  inout  wire  [31:0]       cpu_data,
  input  logic              cpu_mem_read,
  input  logic              cpu_mem_write,
  output logic              cpu_mem_ready,
  output logic              ram_en,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              bus_err,
  output logic [31:0]       err_addr,
  output logic [7:0]        err_count
);

  typedef enum logic [2:0] {IDLE, ACCESS, LATCH, WAIT, DONE} state_t;

  // First byte address past the mapped window; 33 bits so any RAM_AW fits.
  localparam logic [32:0] MAP_LIMIT = 33'd4 << RAM_AW;
  localparam logic [3:0]  WS_INIT   = 4'(WAIT_STATES);

  state_t      state, state_nxt;
  logic        req;
  logic        fault;
  logic        drive;
  logic        lat_write;
  logic [31:0] lat_addr;
  logic [31:0] lat_data;
  logic [31:0] rd_reg;
  logic [3:0]  wait_cnt;

  assign req   = cpu_mem_read | cpu_mem_write;
  assign fault = ({1'b0, lat_addr} >= MAP_LIMIT) || (lat_addr[1:0] != 2'b00);

  assign ram_addr  = lat_addr[RAM_AW+1:2];
  assign ram_wdata = lat_data;
  assign cpu_data  = drive ? rd_reg : 'z;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: fixed-length sequence, DONE always returns to IDLE.
  always_comb begin
    // NOTE: default first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    unique case (state)
      IDLE:    if (req) state_nxt = ACCESS;
      ACCESS:  state_nxt = LATCH;
      LATCH:   state_nxt = (WAIT_STATES > 0) ? WAIT : DONE;
      WAIT:    if (wait_cnt <= 4'd1) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: RAM strobes only in ACCESS, read data only in DONE.
  always_comb begin
    ram_en        = 1'b0;
    ram_we        = 1'b0;
    drive         = 1'b0;
    cpu_mem_ready = ~req;
    unique case (state)
      ACCESS: begin
        ram_en = ~fault;
        ram_we = ~fault & lat_write;
      end
      DONE: begin
        cpu_mem_ready = 1'b1;
        drive         = ~lat_write & cpu_mem_read;
      end
      default: ;
    endcase
  end

  // Request latch, read capture and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_addr  <= '0;
      lat_data  <= '0;
      lat_write <= 1'b0;
      rd_reg    <= '0;
      wait_cnt  <= '0;
    end else begin
      unique case (state)
        IDLE: if (req) begin
          lat_addr  <= cpu_addr;
          lat_data  <= cpu_data;
          lat_write <= cpu_mem_write;
        end
        LATCH: begin
          if (!lat_write) rd_reg <= fault ? 32'h0 : ram_rdata;
          wait_cnt <= WS_INIT;
        end
        WAIT:    wait_cnt <= wait_cnt - 4'd1;
        default: ;
      endcase
    end
  end

  // Error recording: sticky flag, first faulting address, saturating count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_err   <= 1'b0;
      err_addr  <= '0;
      err_count <= '0;
    end else if (state == ACCESS && fault) begin
      bus_err <= 1'b1;
      if (!bus_err) err_addr <= lat_addr;
      if (err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: u1 runs with one wait state (reads,
// faults, saturation, resets), u0 with zero wait states (write timing).
module tb_mem_bus_ctrl;

  logic        clk;
  logic        rst_n;
  int          checks = 0;
  int          errors = 0;

  // u1: WAIT_STATES = 1
  logic [31:0] a1, wd1, rdata1, wdata1, err_addr1;
  logic        rd1, wr1, drv1, ready1, en1, we1, bus_err1;
  logic [17:0] addr1;
  logic [7:0]  err_count1;
  wire  [31:0] bus1;
  logic [31:0] mem [0:255];

  // u0: WAIT_STATES = 0
  logic [31:0] a0, wd0, wdata0, err_addr0;
  logic        rd0, wr0, drv0, ready0, en0, we0, bus_err0;
  logic [17:0] addr0;
  logic [7:0]  err_count0;
  wire  [31:0] bus0;

  assign bus1 = drv1 ? wd1 : 'z;
  assign bus0 = drv0 ? wd0 : 'z;
  wire bus1_z = (bus1 === 32'hzzzzzzzz);
  wire bus0_z = (bus0 === 32'hzzzzzzzz);

  mem_bus_ctrl #(.RAM_AW(18), .WAIT_STATES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .cpu_addr(a1), .cpu_data(bus1),
    .cpu_mem_read(rd1), .cpu_mem_write(wr1), .cpu_mem_ready(ready1),
    .ram_en(en1), .ram_we(we1), .ram_addr(addr1), .ram_wdata(wdata1),
    .ram_rdata(rdata1), .bus_err(bus_err1), .err_addr(err_addr1),
    .err_count(err_count1)
  );

  mem_bus_ctrl #(.RAM_AW(18), .WAIT_STATES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .cpu_addr(a0), .cpu_data(bus0),
    .cpu_mem_read(rd0), .cpu_mem_write(wr0), .cpu_mem_ready(ready0),
    .ram_en(en0), .ram_we(we0), .ram_addr(addr0), .ram_wdata(wdata0),
    .ram_rdata(32'h0), .bus_err(bus_err0), .err_addr(err_addr0),
    .err_count(err_count0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM model for u1; word 0x2000 holds a fixed pattern.
  always @(posedge clk) begin
    if (en1) begin
      if (we1) mem[addr1[7:0]] <= wdata1;
      else     rdata1 <= (addr1 == 18'h2000) ? 32'h12345678 : mem[addr1[7:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full access on u1; starts just after a rising edge with u1 in IDLE.
  task automatic acc1(input string tag, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic exp_en,
                      input logic [31:0] exp_rd);
    a1 = addr; wd1 = wdata; wr1 = wr; rd1 = ~wr; drv1 = wr;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      check({tag, " ready"}, 32'(ready1), 32'(k == 4));
      check({tag, " ram_en"}, 32'(en1), 32'(exp_en && k == 1));
      check({tag, " ram_we"}, 32'(we1), 32'(exp_en && wr && k == 1));
      if (k == 1 && exp_en) begin
        check({tag, " ram_addr"}, 32'(addr1), 32'(addr[19:2]));
        if (wr) check({tag, " ram_wdata"}, wdata1, wdata);
      end
      if (!wr && k == 4)        check({tag, " rdata"}, bus1, exp_rd);
      else if (!wr || k >= 1)   check({tag, " bus_hiz"}, 32'(bus1_z), 32'd1);
      @(posedge clk); #1;
      if (k == 0) drv1 = 1'b0;
      if (k == 4) begin rd1 = 1'b0; wr1 = 1'b0; end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a1 = '0; wd1 = '0; rd1 = 1'b0; wr1 = 1'b0; drv1 = 1'b0;
    a0 = '0; wd0 = '0; rd0 = 1'b0; wr0 = 1'b0; drv0 = 1'b0;
    #3;
    check("rst ready", 32'(ready1), 32'd1);
    check("rst ram_en", 32'(en1), 32'd0);
    check("rst bus_err", 32'(bus_err1), 32'd0);
    check("rst err_addr", err_addr1, 32'h0);
    check("rst err_count", 32'(err_count1), 32'd0);
    check("rst bus_hiz", 32'(bus1_z), 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Mapped read with one wait state.
    acc1("rd8000", 1'b0, 32'h00008000, 32'h0, 1'b1, 32'h12345678);

    // Mapped write then read-back through the RAM model.
    acc1("wr0010", 1'b1, 32'h00000010, 32'hA5A55A5A, 1'b1, 32'h0);
    acc1("rd0010", 1'b0, 32'h00000010, 32'h0, 1'b1, 32'hA5A55A5A);

    // Zero-wait-state write on u0; bus released after the request is latched.
    a0 = 32'h00007000; wd0 = 32'hCAFEBABE; wr0 = 1'b1; drv0 = 1'b1;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      check("wr0 ready", 32'(ready0), 32'(k == 3));
      check("wr0 ram_en", 32'(en0), 32'(k == 1));
      check("wr0 ram_we", 32'(we0), 32'(k == 1));
      if (k == 1) begin
        check("wr0 ram_addr", 32'(addr0), 32'h1C00);
        check("wr0 ram_wdata", wdata0, 32'hCAFEBABE);
      end
      if (k >= 1) check("wr0 bus_hiz", 32'(bus0_z), 32'd1);
      @(posedge clk); #1;
      if (k == 0) drv0 = 1'b0;
      if (k == 3) wr0 = 1'b0;
    end

    // Request withdrawn after one cycle: access finishes silently.
    a1 = 32'h00008000; rd1 = 1'b1;
    @(posedge clk); #1 rd1 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("drop ready", 32'(ready1), 32'd1);
      check("drop bus_hiz", 32'(bus1_z), 32'd1);
      @(posedge clk); #1;
    end

    // Unmapped read, then misaligned write.
    acc1("rd_unmapped", 1'b0, 32'h00200000, 32'h0, 1'b0, 32'h0);
    acc1("wr_misalign", 1'b1, 32'h00007002, 32'h11111111, 1'b0, 32'h0);
    check("flt bus_err", 32'(bus_err1), 32'd1);
    check("flt err_addr", err_addr1, 32'h00200000);
    check("flt err_count", 32'(err_count1), 32'd2);
    acc1("rd0010_after", 1'b0, 32'h00000010, 32'h0, 1'b1, 32'hA5A55A5A);

    // Saturate the error counter.
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0) acc1("sat_rd", 1'b0, 32'hFFFFFFF0, 32'h0, 1'b0, 32'h0);
      else            acc1("sat_wr", 1'b1, 32'h00000101, 32'h0, 1'b0, 32'h0);
    end
    check("sat err_count", 32'(err_count1), 32'hFF);
    check("sat bus_err", 32'(bus_err1), 32'd1);
    check("sat err_addr", err_addr1, 32'h00200000);
    acc1("rd8000_sat", 1'b0, 32'h00008000, 32'h0, 1'b1, 32'h12345678);

    // Asynchronous reset while u1 sits in WAIT.
    a1 = 32'h00008000; rd1 = 1'b1;
    for (int k = 0; k <= 2; k++) begin @(posedge clk); #1; end
    @(negedge clk); #1 rst_n = 1'b0;
    #1;
    check("mid_rst ram_en", 32'(en1), 32'd0);
    check("mid_rst ready_req", 32'(ready1), 32'd0);
    check("mid_rst bus_err", 32'(bus_err1), 32'd0);
    check("mid_rst err_count", 32'(err_count1), 32'd0);
    check("mid_rst err_addr", err_addr1, 32'h0);
    check("mid_rst bus_hiz", 32'(bus1_z), 32'd1);
    rd1 = 1'b0; #1;
    check("mid_rst ready_idle", 32'(ready1), 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst ram_en", 32'(en1), 32'd0);
      check("post_rst ready", 32'(ready1), 32'd1);
      @(posedge clk); #1;
    end

    // Reset during a write's LATCH cycle: nothing more reaches the RAM.
    a1 = 32'h00000020; wd1 = 32'h55555555; wr1 = 1'b1; drv1 = 1'b1;
    @(posedge clk); #1 drv1 = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0; wr1 = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("abort ram_en", 32'(en1), 32'd0);
      @(posedge clk); #1;
    end
    acc1("rd0020", 1'b0, 32'h00000020, 32'h0, 1'b1, 32'h55555555);
    acc1("rd8000_end", 1'b0, 32'h00008000, 32'h0, 1'b1, 32'h12345678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
